// File: rtl/mul_pkg.sv
// Shared types and sizing for the iterative shift-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_STEPS = MUL_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage : mul_pkg

// File: rtl/seq_multiplier.sv
// Signed WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one partial product per cycle,
// answering the ALU mult_begin/mult_end handshake with a registered product.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   mult_begin,
    input  logic [WIDTH-1:0]       mult_op1,
    input  logic [WIDTH-1:0]       mult_op2,
    output logic [2*WIDTH-1:0]     product,
    output logic                   mult_end,
    output logic                   mult_busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    mul_state_t      state_q,   state_d;
    logic [PW-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q,     acc_d;
    logic            neg_q,     neg_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic            end_q,     end_d;
    logic            busy_q,    busy_d;

    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;
    logic [PW-1:0]    sum;

    // Next-state, datapath step and registered-output decode.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        // Magnitudes are unsigned, so |0x80..0| is representable as-is.
        op1_abs = mult_op1[WIDTH-1] ? (~mult_op1 + WIDTH'(1)) : mult_op1;
        op2_abs = mult_op2[WIDTH-1] ? (~mult_op2 + WIDTH'(1)) : mult_op2;
        sum     = acc_q + (mplier_q[0] ? mcand_q : PW'(0));

        case (state_q)
            IDLE: begin
                if (mult_begin) begin
                    mcand_d  = PW'(op1_abs);
                    mplier_d = op2_abs;
                    acc_d    = '0;
                    neg_d    = mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1];
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (!mult_begin) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        product_d = neg_q ? (~sum + PW'(1)) : sum;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        end_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            end_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            end_q     <= end_d;
            busy_q    <= busy_d;
        end
    end

    assign product   = product_q;
    assign mult_end  = end_q;
    assign mult_busy = busy_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: handshake timing, signed corner products,
// back-to-back jobs, abort and asynchronous reset.
module tb_seq_multiplier;

    logic        clk;
    logic        resetn;
    logic        mult_begin;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] product;
    logic        mult_end;
    logic        mult_busy;

    int n_checks;
    int n_errors;
    logic [63:0] exp_q[$];

    seq_multiplier #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mult_begin (mult_begin),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .product    (product),
        .mult_end   (mult_end),
        .mult_busy  (mult_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return 64'(ea * eb);
    endfunction

    // Waits for mult_end; returns ticks taken (0 on timeout, counted as a failure).
    task automatic wait_end(input string tag, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (mult_end) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) chk({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic pop_and_check(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_product"}, product, e);
        end
    endtask

    // Full single job from IDLE, begin dropped right after completion.
    task automatic do_job(input string tag, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        mult_op1   = a;
        mult_op2   = b;
        mult_begin = 1'b1;
        exp_q.push_back(ref_mul(a, b));
        tick();
        chk({tag, "_busy"}, 64'(mult_busy), 64'(1));
        mult_op1 = $urandom;
        mult_op2 = $urandom;
        wait_end(tag, cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'(32));
        pop_and_check(tag);
        mult_begin = 1'b0;
        tick();
        chk({tag, "_end_drop"}, 64'(mult_end), 64'(0));
        chk({tag, "_busy_drop"}, 64'(mult_busy), 64'(0));
    endtask

    initial begin
        int cyc;
        logic [63:0] prev;
        n_checks   = 0;
        n_errors   = 0;
        resetn     = 1'b0;
        mult_begin = 1'b0;
        mult_op1   = '0;
        mult_op2   = '0;
        tick();
        tick();
        chk("rst_product", product, 64'(0));
        chk("rst_end", 64'(mult_end), 64'(0));
        chk("rst_busy", 64'(mult_busy), 64'(0));
        resetn = 1'b1;
        tick();

        do_job("m3x5", 32'd3, 32'd5);
        chk("m3x5_value", product, 64'h0000_0000_0000_000F);
        do_job("mneg7x6", 32'hFFFF_FFF9, 32'd6);
        chk("mneg7x6_value", product, 64'hFFFF_FFFF_FFFF_FFD6);
        do_job("mm1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mm1xm1_value", product, 64'h1);
        do_job("mmin_sq", 32'h8000_0000, 32'h8000_0000);
        chk("mmin_sq_value", product, 64'h4000_0000_0000_0000);
        do_job("mminx1", 32'h8000_0000, 32'd1);
        chk("mminx1_value", product, 64'hFFFF_FFFF_8000_0000);
        do_job("mrand", 32'h1234_5678, 32'h9ABC_DEF0);

        // Back-to-back with begin held; new operands presented at the DONE edge.
        mult_op1   = 32'd2;
        mult_op2   = 32'd3;
        mult_begin = 1'b1;
        exp_q.push_back(ref_mul(32'd2, 32'd3));
        tick();
        wait_end("b2b1", cyc);
        chk("b2b1_latency", 64'(cyc), 64'(32));
        pop_and_check("b2b1");
        mult_op1 = 32'd0;
        mult_op2 = 32'h1234;
        exp_q.push_back(64'(0));
        wait_end("b2b2", cyc);
        chk("b2b2_spacing", 64'(cyc), 64'(34));
        pop_and_check("b2b2");
        mult_begin = 1'b0;
        tick();
        chk("b2b2_busy_drop", 64'(mult_busy), 64'(0));

        // Abort: previous product (0) replaced first by a real one, then abort 9x9.
        do_job("pre_abort", 32'd11, 32'd13);
        prev = product;
        mult_op1   = 32'd9;
        mult_op2   = 32'd9;
        mult_begin = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        mult_begin = 1'b0;
        tick();
        chk("abort_busy", 64'(mult_busy), 64'(0));
        chk("abort_product", product, prev);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mult_end) cyc++;
        end
        chk("abort_no_end", 64'(cyc), 64'(0));

        // Asynchronous reset mid-job, between clock edges.
        mult_op1   = 32'd100;
        mult_op2   = 32'd200;
        mult_begin = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_product", product, 64'(0));
        chk("arst_busy", 64'(mult_busy), 64'(0));
        chk("arst_end", 64'(mult_end), 64'(0));
        tick();
        #2;
        resetn = 1'b1;
        do_job("post_rst", 32'hFFFF_FF00, 32'd77);

        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_multiplier
